ysyx_22040125_lsu: RTL and testbench

//  - MEM-stage load/store unit: takes one memory op from EX, drives the data-memory

---
 rtl/ysyx_22040125_lsu_pkg.sv | 53 +++++
 rtl/ysyx_22040125_lsu_if.sv | 38 +++
 rtl/ysyx_22040125_ld_fmt.sv | 31 +++
 rtl/ysyx_22040125_lsu.sv | 140 ++++++++++++++
 tb/tb_ysyx_22040125_lsu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, access sizes,
// FSM states and the size/alignment helpers used by the datapath.
package ysyx_22040125_lsu_pkg;

    localparam int unsigned LsuXlen  = 64;
    localparam int unsigned LsuStrbW = LsuXlen / 8;

    // RV64 load/store funct3 encodings
    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3D  = 3'b011;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;
    localparam logic [2:0] Funct3Wu = 3'b110;

    // Access size, taken from funct3[1:0]
    localparam logic [1:0] SizeB = 2'b00;
    localparam logic [1:0] SizeH = 2'b01;
    localparam logic [1:0] SizeW = 2'b10;
    localparam logic [1:0] SizeD = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StResp = 2'b10
    } lsu_state_e;

    // Byte-enable mask for an access of the given size, aligned to lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SizeB:   mask = 8'h01;
            SizeH:   mask = 8'h03;
            SizeW:   mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask;
    endfunction

    // True when the byte offset is not a multiple of the access size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        logic bad;
        case (size)
            SizeB:   bad = 1'b0;
            SizeH:   bad = offset[0];
            SizeW:   bad = |offset[1:0];
            default: bad = |offset;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface ysyx_22040125_lsu_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STRB_W = XLEN / 8
) ();

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_rsp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_rsp_valid,
        output mem_rdata
    );

endinterface

// File: rtl/ysyx_22040125_ld_fmt.sv
// Load formatter: selects the addressed bytes from a full bus beat and sign- or
// zero-extends them to XLEN. Purely combinational.
module ysyx_22040125_ld_fmt
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;
    logic            zext;

    assign shifted = rdata_i >> {offset_i, 3'b000};
    assign zext    = funct3_i[2];

    // Keep the access-size bytes and extend according to funct3[2]
    always_comb begin
        data_o = shifted;
        case (funct3_i[1:0])
            SizeB: data_o = {{(XLEN-8){~zext & shifted[7]}}, shifted[7:0]};
            SizeH: data_o = {{(XLEN-16){~zext & shifted[15]}}, shifted[15:0]};
            SizeW: data_o = {{(XLEN-32){~zext & shifted[31]}}, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// MEM-stage load/store unit. Accepts one op from EX, issues it on the data-memory bus
// and stalls the pipeline until it retires: stores retire on request accept, loads on
// the response. Optional misaligned-access trap under YSYX_22040125_MISALIGN_TRAP_EN.
module ysyx_22040125_lsu
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = LsuXlen,
    parameter int unsigned STRB_W = LsuStrbW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              stall_o,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_data,
    output logic              out_fault,
    ysyx_22040125_lsu_if.master mem
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            store_q, store_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] ld_data;

    // No relaunch while retiring, so the pipeline gets one free cycle to advance
    assign stall_o = in_valid & (in_is_load | in_is_store) & ~out_valid_q;

`ifdef YSYX_22040125_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = is_misaligned(in_funct3[1:0], in_addr[2:0]);
`endif

    ysyx_22040125_ld_fmt #(
        .XLEN (XLEN)
    ) u_ld_fmt (
        .rdata_i  (mem.mem_rdata),
        .offset_i (addr_q[2:0]),
        .funct3_i (funct3_q),
        .data_o   (ld_data)
    );

    // Next-state: launch in IDLE, hold request until accepted, capture load response
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        store_d     = store_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        fault_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stall_o) begin
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    funct3_d = in_funct3;
                    store_d  = in_is_store;
`ifdef YSYX_22040125_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        // Trap without touching the bus; retire next cycle
                        out_valid_d = 1'b1;
                        fault_d     = 1'b1;
                        out_data_d  = '0;
                    end else begin
                        state_d = StReq;
                    end
`else
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                if (mem.mem_req_ready) begin
                    if (store_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        state_d     = StIdle;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (mem.mem_rsp_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = ld_data;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            store_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            store_q     <= store_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            fault_q     <= fault_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_fault = fault_q;

    // Bus fields come from latched values so they stay stable under backpressure
    assign mem.mem_req_valid = (state_q == StReq);
    assign mem.mem_we        = store_q;
    assign mem.mem_addr      = {addr_q[XLEN-1:3], 3'b000};
    assign mem.mem_wdata     = wdata_q << {addr_q[2:0], 3'b000};
    assign mem.mem_wstrb     = store_q ? (STRB_W'(size_mask(funct3_q[1:0])) << addr_q[2:0])
                                       : '0;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Directed self-checking bench for ysyx_22040125_lsu. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_ysyx_22040125_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        stall_o;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_fault;

    int checks;
    int errors;

    ysyx_22040125_lsu_if mem_bus ();

    ysyx_22040125_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_is_load  (in_is_load),
        .in_is_store (in_is_store),
        .in_funct3   (in_funct3),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .stall_o     (stall_o),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_fault   (out_fault),
        .mem         (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wd);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wd;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_addr     = 64'h0;
        in_wdata    = 64'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rdata     = 64'h0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got %0h want 0", out_data); end
        checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL rst_out_fault got %0h want 0", out_fault); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h want 0", stall_o); end
        checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0h want 0", mem_bus.mem_req_valid); end
        checks++; if (mem_bus.mem_wstrb !== 8'h00) begin errors++; $display("FAIL rst_wstrb got %0h want 0", mem_bus.mem_wstrb); end
        rst = 1'b1;
        step();
    endtask

    // Load with ready=1 at launch and the response one cycle after accept
    task automatic test_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] rdata, input logic [63:0] exp);
        drive_op(1'b1, 1'b0, f3, addr, 64'h0);
        mem_bus.mem_req_ready = 1'b1;
        step();
        checks++; if (mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL %s req_valid got %0h want 1", name, mem_bus.mem_req_valid); end
        checks++; if (mem_bus.mem_addr !== {addr[63:3], 3'b000}) begin errors++; $display("FAIL %s addr got %0h want %0h", name, mem_bus.mem_addr, {addr[63:3], 3'b000}); end
        checks++; if (mem_bus.mem_we !== 1'b0 || mem_bus.mem_wstrb !== 8'h00) begin errors++; $display("FAIL %s read_fields we %0h wstrb %0h want 0 0", name, mem_bus.mem_we, mem_bus.mem_wstrb); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL %s stall got %0h want 1", name, stall_o); end
        step();
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = rdata;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid got %0h want 0", name, out_valid); end
        step();
        mem_bus.mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got %0h want 1", name, out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL %s out_data got %0h want %0h", name, out_data, exp); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL %s retire_stall got %0h want 0", name, stall_o); end
        idle_inputs();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s pulse_len got %0h want 0", name, out_valid); end
    endtask

    task automatic test_store_sh();
        drive_op(1'b0, 1'b1, 3'b001, 64'h80000006, 64'h000000000000ABCD);
        mem_bus.mem_req_ready = 1'b1;
        step();
        checks++; if (mem_bus.mem_wstrb !== 8'hC0) begin errors++; $display("FAIL sh_wstrb got %0h want c0", mem_bus.mem_wstrb); end
        checks++; if (mem_bus.mem_wdata !== 64'hABCD000000000000) begin errors++; $display("FAIL sh_wdata got %0h want abcd000000000000", mem_bus.mem_wdata); end
        checks++; if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL sh_req we %0h valid %0h want 1 1", mem_bus.mem_we, mem_bus.mem_req_valid); end
        checks++; if (mem_bus.mem_addr !== 64'h80000000) begin errors++; $display("FAIL sh_addr got %0h want 80000000", mem_bus.mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sh_early_valid got %0h want 0", out_valid); end
        step();
        mem_bus.mem_req_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h0) begin errors++; $display("FAIL sh_retire valid %0h data %0h want 1 0", out_valid, out_data); end
        checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL sh_req_drop got %0h want 0", mem_bus.mem_req_valid); end
        idle_inputs();
        step();
    endtask

    task automatic test_backpressure();
        drive_op(1'b0, 1'b1, 3'b011, 64'h80000010, 64'h0123456789ABCDEF);
        mem_bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_addr !== 64'h80000010) begin errors++; $display("FAIL bp_req[%0d] valid %0h addr %0h want 1 80000010", i, mem_bus.mem_req_valid, mem_bus.mem_addr); end
            checks++; if (mem_bus.mem_wdata !== 64'h0123456789ABCDEF || mem_bus.mem_wstrb !== 8'hFF) begin errors++; $display("FAIL bp_fields[%0d] wdata %0h wstrb %0h want 123456789abcdef ff", i, mem_bus.mem_wdata, mem_bus.mem_wstrb); end
            checks++; if (stall_o !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d] stall %0h valid %0h want 1 0", i, stall_o, out_valid); end
        end
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_retire got %0h want 1", out_valid); end
        idle_inputs();
        step();
        checks++; if (out_valid !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_single valid %0h req %0h want 0 0", out_valid, mem_bus.mem_req_valid); end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b0, 1'b1, 3'b000, 64'h80000001, 64'h5A);
        mem_bus.mem_req_ready = 1'b1;
        step();
        checks++; if (mem_bus.mem_wstrb !== 8'h02 || mem_bus.mem_wdata !== 64'h5A00) begin errors++; $display("FAIL b2b_sb wstrb %0h wdata %0h want 02 5a00", mem_bus.mem_wstrb, mem_bus.mem_wdata); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_retire1 got %0h want 1", out_valid); end
        // Next op arrives during the retire cycle; it must wait one cycle to launch
        drive_op(1'b0, 1'b1, 3'b010, 64'h80000004, 64'hDEADBEEF);
        step();
        checks++; if (mem_bus.mem_req_valid !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL b2b_gap req %0h stall %0h want 0 1", mem_bus.mem_req_valid, stall_o); end
        step();
        checks++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_wstrb !== 8'hF0) begin errors++; $display("FAIL b2b_sw req %0h wstrb %0h want 1 f0", mem_bus.mem_req_valid, mem_bus.mem_wstrb); end
        checks++; if (mem_bus.mem_wdata !== 64'hDEADBEEF00000000) begin errors++; $display("FAIL b2b_sw_wdata got %0h want deadbeef00000000", mem_bus.mem_wdata); end
        step();
        mem_bus.mem_req_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_retire2 got %0h want 1", out_valid); end
        idle_inputs();
        step();
    endtask

    task automatic test_ignore();
        drive_op(1'b0, 1'b0, 3'b000, 64'h80000000, 64'h0);
        mem_bus.mem_req_ready = 1'b1;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = 64'hFFFF;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ign_stall got %0h want 0", stall_o); end
        step();
        checks++; if (mem_bus.mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ign_idle req %0h valid %0h want 0 0", mem_bus.mem_req_valid, out_valid); end
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        drive_op(1'b1, 1'b0, 3'b011, 64'h80000020, 64'h0);
        mem_bus.mem_req_ready = 1'b1;
        step();
        step();
        mem_bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle_inputs();
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = 64'hCAFE;
        checks++; if (out_valid !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after valid %0h req %0h want 0 0", out_valid, mem_bus.mem_req_valid); end
        step();
        mem_bus.mem_rsp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin errors++; $display("FAIL rstmid_drop valid %0h data %0h want 0 0", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle valid %0h req %0h want 0 0", out_valid, mem_bus.mem_req_valid); end
    endtask

    task automatic test_misalign();
`ifdef YSYX_22040125_MISALIGN_TRAP_EN
        drive_op(1'b1, 1'b0, 3'b010, 64'h80000002, 64'h0);
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        checks++; if (mem_bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_noreq got %0h want 0", mem_bus.mem_req_valid); end
        checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_data !== 64'h0) begin errors++; $display("FAIL mis_trap valid %0h fault %0h data %0h want 1 1 0", out_valid, out_fault, out_data); end
        idle_inputs();
        step();
        checks++; if (out_fault !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_clear fault %0h valid %0h want 0 0", out_fault, out_valid); end
`else
        test_load("mis_lw", 3'b010, 64'h80000002, 64'h0000876543210000, 64'hFFFFFFFF87654321);
        checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL mis_fault got %0h want 0", out_fault); end
        // Store crossing the beat: upper bytes are dropped
        drive_op(1'b0, 1'b1, 3'b010, 64'h80000006, 64'h11223344);
        mem_bus.mem_req_ready = 1'b1;
        step();
        checks++; if (mem_bus.mem_wstrb !== 8'hC0 || mem_bus.mem_wdata !== 64'h3344000000000000) begin errors++; $display("FAIL mis_sw wstrb %0h wdata %0h want c0 3344000000000000", mem_bus.mem_wstrb, mem_bus.mem_wdata); end
        step();
        mem_bus.mem_req_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_fault !== 1'b0) begin errors++; $display("FAIL mis_sw_retire valid %0h fault %0h want 1 0", out_valid, out_fault); end
        idle_inputs();
        step();
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_load("ld", 3'b011, 64'h80000008, 64'h1122334455667788, 64'h1122334455667788);
        test_load("lb", 3'b000, 64'h80000003, 64'h00000000F0000000, 64'hFFFFFFFFFFFFFFF0);
        test_load("lbu", 3'b100, 64'h80000003, 64'h00000000F0000000, 64'h00000000000000F0);
        test_load("lhu", 3'b101, 64'h80000002, 64'h00000000F0E10000, 64'h000000000000F0E1);
        test_store_sh();
        test_backpressure();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
